// File: rtl/shop_decoder_v_pkg.sv
// Shared constants for the shop function unit and its readback decoder:
// function codes, their 8-entry truth tables, and the decoder FSM encoding.
package shop_pkg_v;

  localparam logic [1:0] CODE_XOR3  = 2'b00;
  localparam logic [1:0] CODE_NAND3 = 2'b01;
  localparam logic [1:0] CODE_NOR3  = 2'b10;
  localparam logic [1:0] CODE_XNOR3 = 2'b11;

  // bit n of each table is f at {a,b,c} = n
  localparam logic [7:0] TT_XOR3  = 8'h96;
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_XNOR3 = 8'h69;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/shop_tt_match_v.sv
// Maps a captured 8-bit truth table back to the shop function code.
// Unknown patterns report valid_o = 0 with code 00.
module shop_tt_match_v
  import shop_pkg_v::*;
(
  input  logic [7:0] pattern_i,
  output logic       valid_o,
  output logic [1:0] code_o
);

  always_comb begin
    valid_o = 1'b1;
    code_o  = CODE_XOR3;
    if (pattern_i == TT_XOR3) begin
      code_o = CODE_XOR3;
    end else if (pattern_i == TT_NAND3) begin
      code_o = CODE_NAND3;
    end else if (pattern_i == TT_NOR3) begin
      code_o = CODE_NOR3;
    end else if (pattern_i == TT_XNOR3) begin
      code_o = CODE_XNOR3;
    end else begin
      valid_o = 1'b0;
      code_o  = CODE_XOR3;
    end
  end

endmodule

// File: rtl/shop_decoder_v.sv
// Sweeps all eight {a,b,c} combinations into a shop unit, captures f,
// and decodes which function code the unit is running.
module shop_decoder_v
  import shop_pkg_v::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_f,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic [7:0] o_cap
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [2:0] idx_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       valid_q;
  logic [1:0] code_q;
  logic [7:0] cap_q;

  logic       match_valid;
  logic [1:0] match_code;

  shop_tt_match_v u_match (
    .pattern_i (cap_q),
    .valid_o   (match_valid),
    .code_o    (match_code)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= 2'b00;
      cap_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_DRIVE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cap_q[idx_q] <= i_f;
            cnt_q        <= 4'd0;
            // index doubles as the a/b/c stimulus, so park it at 0 on exit
            if (idx_q == 3'd7) begin
              state_q <= ST_RESULT;
              idx_q   <= 3'd0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_RESULT: begin
          valid_q <= match_valid;
          code_q  <= match_code;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_a     = idx_q[2];
  assign o_b     = idx_q[1];
  assign o_c     = idx_q[0];
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_valid = valid_q;
  assign o_code  = code_q;
  assign o_cap   = cap_q;

endmodule

// File: tb/tb_shop_decoder_v.sv
// Directed bench for shop_decoder_v: two instances (settle 1 and 3) each
// looped through a behavioural shop unit model.
module tb_shop_decoder_v;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] code = 2'b00;
  int fmode = 0;   // 0: shop model, 1: f tied 1, 2: f tied 0
  int s_sel = 1;

  logic start1 = 1'b0, start3 = 1'b0;
  logic f1, a1, b1, c1, busy1, done1, valid1;
  logic f3, a3, b3, c3, busy3, done3, valid3;
  logic [1:0] code1, code3;
  logic [7:0] cap1, cap3;

  function automatic logic shop_f(input logic [1:0] c, input logic [2:0] x);
    case (c)
      2'b00:   return x[2] ^ x[1] ^ x[0];
      2'b01:   return ~(x[2] & x[1] & x[0]);
      2'b10:   return ~(x[2] | x[1] | x[0]);
      default: return ~(x[2] ^ x[1] ^ x[0]);
    endcase
  endfunction

  assign f1 = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'b0 : shop_f(code, {a1, b1, c1});
  assign f3 = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'b0 : shop_f(code, {a3, b3, c3});

  shop_decoder_v #(.SETTLE_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_f(f1),
    .o_a(a1), .o_b(b1), .o_c(c1), .o_busy(busy1), .o_done(done1),
    .o_valid(valid1), .o_code(code1), .o_cap(cap1)
  );

  shop_decoder_v #(.SETTLE_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_f(f3),
    .o_a(a3), .o_b(b3), .o_c(c3), .o_busy(busy3), .o_done(done3),
    .o_valid(valid3), .o_code(code3), .o_cap(cap3)
  );

  logic       done_m, busy_m, valid_m;
  logic [1:0] code_m;
  logic [7:0] cap_m;
  assign done_m  = (s_sel == 3) ? done3  : done1;
  assign busy_m  = (s_sel == 3) ? busy3  : busy1;
  assign valid_m = (s_sel == 3) ? valid3 : valid1;
  assign code_m  = (s_sel == 3) ? code3  : code1;
  assign cap_m   = (s_sel == 3) ? cap3   : cap1;

  task automatic set_start(input logic v);
    if (s_sel == 3) start3 = v;
    else start1 = v;
  endtask

  task automatic sweep(input int s, input logic [7:0] exp_cap, input logic exp_valid,
                       input logic [1:0] exp_code, input string name);
    int  edges;
    bit  seen;
    s_sel = s;
    @(negedge clk); set_start(1'b1);
    @(posedge clk); #1;
    checks++;
    if (busy_m !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy_m);
    end
    @(negedge clk); set_start(1'b0);
    seen = 0;
    for (edges = 1; edges <= 100; edges++) begin
      @(posedge clk); #1;
      if (done_m === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || edges != 8 * s + 1) begin
      errors++; $display("FAIL %s latency: got %0d edges (seen=%0d) expected %0d", name, edges, seen, 8 * s + 1);
    end
    checks++;
    if (cap_m !== exp_cap) begin
      errors++; $display("FAIL %s cap: got %h expected %h", name, cap_m, exp_cap);
    end
    checks++;
    if (valid_m !== exp_valid || code_m !== exp_code) begin
      errors++; $display("FAIL %s result: got valid=%b code=%b expected valid=%b code=%b",
                         name, valid_m, code_m, exp_valid, exp_code);
    end
    checks++;
    if (busy_m !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy_m);
    end
    @(posedge clk); #1;
    checks++;
    if (done_m !== 1'b0) begin
      errors++; $display("FAIL %s done_width: got %b expected 0", name, done_m);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a1, b1, c1, busy1, done1, valid1, code1, cap1} !== 15'd0 ||
        {a3, b3, c3, busy3, done3, valid3, code3, cap3} !== 15'd0) begin
      errors++; $display("FAIL reset_state: got dut1 cap=%h code=%b busy=%b dut3 cap=%h code=%b busy=%b expected all 0",
                         cap1, code1, busy1, cap3, code3, busy3);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_codes(input int s);
    logic [7:0] tt [4];
    tt[0] = 8'h96; tt[1] = 8'h7F; tt[2] = 8'h01; tt[3] = 8'h69;
    for (int c = 0; c < 4; c++) begin
      code = 2'(c);
      sweep(s, tt[c], 1'b1, 2'(c), $sformatf("code%0d_s%0d", c, s));
    end
  endtask

  task automatic test_tied();
    fmode = 1;
    sweep(1, 8'hFF, 1'b0, 2'b00, "tied1");
    fmode = 2;
    sweep(1, 8'h00, 1'b0, 2'b00, "tied0");
    fmode = 0;
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int dedge = -1;
    code = 2'b00; s_sel = 1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start1 = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin ndone++; dedge = e; end
      if (e == 3) begin @(negedge clk); start1 = 1'b1; end
      else if (e == 4) begin @(negedge clk); start1 = 1'b0; end
    end
    checks++;
    if (ndone != 1 || dedge != 9) begin
      errors++; $display("FAIL ignore_start: got %0d dones last at edge %0d expected 1 at edge 9", ndone, dedge);
    end
    checks++;
    if (cap1 !== 8'h96 || valid1 !== 1'b1) begin
      errors++; $display("FAIL ignore_start_result: got cap=%h valid=%b expected 96 1", cap1, valid1);
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    code = 2'b10; s_sel = 1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start1 = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    checks++;
    if ({a1, b1, c1, busy1, done1, valid1, code1, cap1} !== 15'd0) begin
      errors++; $display("FAIL reset_mid: got abc=%b%b%b busy=%b valid=%b code=%b cap=%h expected all 0",
                         a1, b1, c1, busy1, valid1, code1, cap1);
    end
    @(negedge clk); rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d dones expected 0", ndone);
    end
    sweep(1, 8'h01, 1'b1, 2'b10, "after_reset");
  endtask

  task automatic test_back_to_back();
    int  ndone = 0;
    bit  seen = 0;
    code = 2'b01; s_sel = 1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 35; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin
        ndone++;
        checks++;
        if (e != 9 + 10 * (ndone - 1) || code1 !== 2'b01 || valid1 !== 1'b1) begin
          errors++; $display("FAIL b2b_done%0d: got edge %0d code=%b valid=%b expected edge %0d code=01 valid=1",
                             ndone, e, code1, valid1, 9 + 10 * (ndone - 1));
        end
      end
    end
    @(negedge clk); start1 = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++; $display("FAIL b2b_count: got %0d dones expected 3", ndone);
    end
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || busy1 !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got seen=%0d busy=%b expected 1 0", seen, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_codes(1);
    test_codes(3);
    test_tied();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
